// File: rtl/muldiv_unit_if.sv
// muldiv_if: request/result handshake bundle between decode, the muldiv unit and writeback.
interface muldiv_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        busy;
    modport master (
        output in_valid, op, rs1_val, rs2_val, rd_in, flush, out_ready,
        input  in_ready, out_valid, out_rd, out_data, busy
    );
    modport slave (
        input  in_valid, op, rs1_val, rs2_val, rd_in, flush, out_ready,
        output in_ready, out_valid, out_rd, out_data, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide, one bit per cycle (shift-add / restoring division).
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier instead.
module muldiv_unit (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt, r_rd;
    logic [1:0]  r_op;
    logic        r_neg;
    logic [31:0] r_b, r_hi, r_lo, r_out_data;
    logic        w_div_op, w_sa, w_sb, w_na, w_nb, w_neg, w_dz, w_ovf, w_direct, w_dok;
    logic [31:0] w_ma, w_mb, w_spec, w_direct_data;
    logic [31:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo, w_mul_res, w_div_val, w_div_res;
    logic [32:0] w_madd, w_dsh;
    logic [33:0] w_dsub;
    logic [63:0] w_prod, w_sprod;
    assign w_div_op = bus.op[2];
    assign w_sa     = w_div_op ? !bus.op[0] : (bus.op[1:0] != 2'b11);
    assign w_sb     = w_div_op ? !bus.op[0] : !bus.op[1];
    assign w_na     = w_sa & bus.rs1_val[31];
    assign w_nb     = w_sb & bus.rs2_val[31];
    assign w_ma     = w_na ? -bus.rs1_val : bus.rs1_val;
    assign w_mb     = w_nb ? -bus.rs2_val : bus.rs2_val;
    // Remainders follow the dividend; everything else follows the operand signs.
    assign w_neg    = (w_div_op & bus.op[1]) ? w_na : w_na ^ w_nb;
    assign w_dz     = bus.rs2_val == 32'd0;
    assign w_ovf    = !bus.op[0] && bus.rs1_val == 32'h8000_0000 && bus.rs2_val == 32'hFFFF_FFFF;
    assign w_spec   = w_dz ? (bus.op[1] ? bus.rs1_val : 32'hFFFF_FFFF)
                           : (bus.op[1] ? 32'd0 : 32'h8000_0000);
`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] w_fprod;
    assign w_fprod       = $signed({w_sa & bus.rs1_val[31], bus.rs1_val}) *
                           $signed({w_sb & bus.rs2_val[31], bus.rs2_val});
    assign w_direct      = w_div_op ? (w_dz | w_ovf) : 1'b1;
    assign w_direct_data = w_div_op ? w_spec
                         : (bus.op[1:0] == 2'b00 ? w_fprod[31:0] : w_fprod[63:32]);
`else
    assign w_direct      = w_div_op & (w_dz | w_ovf);
    assign w_direct_data = w_spec;
`endif
    // Multiply: {r_hi,r_lo} shifts right, r_lo starts as the multiplier, r_b is the multiplicand.
    assign w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_hi  = w_madd[32:1];
    assign w_mul_lo  = {w_madd[0], r_lo[31:1]};
    assign w_prod    = {w_mul_hi, w_mul_lo};
    assign w_sprod   = r_neg ? -w_prod : w_prod;
    assign w_mul_res = r_op == 2'b00 ? w_sprod[31:0] : w_sprod[63:32];
    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
    assign w_dsh     = {r_hi, r_lo[31]};
    assign w_dsub    = {1'b0, w_dsh} - {2'b00, r_b};
    assign w_dok     = !w_dsub[33];
    assign w_div_hi  = w_dok ? w_dsub[31:0] : w_dsh[31:0];
    assign w_div_lo  = {r_lo[30:0], w_dok};
    assign w_div_val = r_op[1] ? w_div_hi : w_div_lo;
    assign w_div_res = r_neg ? -w_div_val : w_div_val;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_out_data <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_op  <= bus.op[1:0];
                    r_rd  <= bus.rd_in;
                    r_neg <= w_neg;
                    r_cnt <= 5'd31;
                    r_hi  <= '0;
                    r_b   <= w_div_op ? w_mb : w_ma;
                    r_lo  <= w_div_op ? w_ma : w_mb;
                    if (w_direct) begin
                        r_out_data <= w_direct_data;
                        r_state    <= DONE;
                    end else begin
                        r_state <= w_div_op ? DIV : MUL;
                    end
                end
                MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_out_data <= w_mul_res;
                        r_state    <= DONE;
                    end
                end
                DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_out_data <= w_div_res;
                        r_state    <= DONE;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = r_state == IDLE;
    assign bus.busy      = r_state != IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.out_data  = r_out_data;
    assign bus.out_rd    = r_rd;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request from decode, with register-file operands.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_val  input  32  operand A, from register-file read port 1.
REQ-008 rs2_val  input  32  operand B, from register-file read port 2.
REQ-009 rd_in  input  5  destination register index.
REQ-010 flush  input  1  synchronous kill of the in-flight operation.
REQ-011 out_valid  output  1  result available for writeback.
REQ-012 out_ready  input  1  writeback accepts the result.
REQ-013 out_rd  output  5  destination index, passed to the register-file write address.
REQ-014 out_data  output  32  result, passed to the register-file write data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, MUL, DIV and DONE; in_ready SHALL equal (state==IDLE).
REQ-017 Acceptance SHALL occur on an edge where in_valid && in_ready; on acceptance the unit SHALL latch op, rd_in, operand magnitudes and result sign, and load a 5-bit counter with 31.
REQ-018 After acceptance, mul ops SHALL enter MUL and div ops SHALL enter DIV.
REQ-019 MUL and DIV SHALL each process one bit per cycle: shift-add for 32x32 to 64-bit unsigned, restoring division for 32-bit quotient and remainder.
REQ-020 After the iteration with counter==0, the FSM SHALL go to DONE, giving out_valid high after exactly 32 edges following the accept edge.
REQ-021 Signedness SHALL be: MUL/MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU, DIVU, REMU unsigned; DIV/REM signed.
REQ-022 Signed division SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-023 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-024 For divide by zero (rs2_val==0), DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return rs1_val.
REQ-025 For signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-026 The special cases in REQ-024 and REQ-025 SHALL go directly from IDLE to DONE, setting out_valid after the edge following the accept edge.
REQ-027 In DONE, out_valid SHALL be 1 and out_data/out_rd SHALL be held stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-028 A new request SHALL NOT be accepted on the same edge as result handoff.
REQ-029 flush SHALL force IDLE on the next edge from any state, discarding the result and clearing out_valid.
REQ-030 flush SHALL have priority over acceptance and over handoff.
REQ-031 in_valid SHALL be ignored while in_ready is low.
REQ-032 rd_in==0 SHALL be processed normally; suppressing the write is the register file's responsibility.

Reset
REQ-033 On rst_n low, the state SHALL become IDLE immediately, independent of clk, aborting any in-flight operation.
REQ-034 Reset values SHALL be: out_valid 0, out_data 0, out_rd 0, busy 0, in_ready 1 after release, and all internal datapath registers 0.

Configuration
REQ-035 With MULDIV_FAST_MUL_EN defined, all mul ops SHALL use a single-cycle combinational 32x32 multiplier and go from IDLE directly to DONE; out_valid SHALL be high after the edge following acceptance, and the MUL state SHALL be unused.
REQ-036 Without MULDIV_FAST_MUL_EN, mul ops SHALL use the iterative 32-cycle path of REQ-019 and REQ-020; divide behaviour SHALL be identical in both builds.

Verification
REQ-037 MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd 5 -> after 32 edges: out_data 0xFFFFFFEB, out_rd 5; with MULDIV_FAST_MUL_EN, after 1 edge.
REQ-038 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF after 1 edge; REMU 100/0 -> 100.
REQ-040 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 edge; REM on the same operands -> 0.
REQ-041 Hold out_ready low 5 cycles in DONE -> out_data and out_rd stable and in_ready low; on out_ready high -> IDLE, in_ready high on the next cycle.
REQ-042 flush at iteration 10 of DIVU -> IDLE on the next edge with no out_valid; rst_n low mid-DIV -> immediate IDLE with outputs 0, and a new request after release completes correctly.
